// File: rtl/reg_file_wb_ctrl.sv
// reg_file_wb_ctrl: write-port controller for the register file.
// After reset it zeroes every register through the single write port,
// then arbitrates that port round-robin between the ALU and load-unit
// writeback sources. All register-file controls come straight from flops.
module reg_file_wb_ctrl #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [$clog2(NREG)-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [$clog2(NREG)-1:0] mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  output logic [$clog2(NREG)-1:0] write_reg,
  output logic [XLEN-1:0]         write_data,
  output logic                    reg_write,
  output logic                    init_done
);

  localparam int RW = $clog2(NREG);

  // Source encoding for the round-robin pointer.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [RW-1:0]   cnt;
  logic            last;
  logic            sweep_last;

  assign sweep_last = (cnt == RW'(NREG - 1));

  // State register: the sweep restarts on every reset.
  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Next state: leave the sweep once the final register has been issued.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_last) state_next = ARB;
      ARB:     state_next = ARB;
      default: state_next = INIT;
    endcase
  end

  // Readies: a lone requester wins, a tie goes to the source not granted last.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (state == ARB) begin
      if (alu_valid && mem_valid) begin
        alu_ready = (last == SRC_MEM);
        mem_ready = (last == SRC_ALU);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  // Write-port registers, sweep counter and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      last       <= SRC_MEM;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      init_done  <= 1'b0;
    end else if (state == INIT) begin
      write_reg  <= cnt;
      write_data <= '0;
      reg_write  <= 1'b1;
      cnt        <= cnt + 1'b1;
      if (sweep_last) init_done <= 1'b1;
    end else if (alu_valid && alu_ready) begin
      last <= SRC_ALU;
      if (alu_rd != '0) begin
        reg_write  <= 1'b1;
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else begin
        reg_write  <= 1'b0;
        write_reg  <= '0;
        write_data <= '0;
      end
    end else if (mem_valid && mem_ready) begin
      last <= SRC_MEM;
      if (mem_rd != '0) begin
        reg_write  <= 1'b1;
        write_reg  <= mem_rd;
        write_data <= mem_data;
      end else begin
        reg_write  <= 1'b0;
        write_reg  <= '0;
        write_data <= '0;
      end
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_wb_ctrl.sv
// tb_reg_file_wb_ctrl: directed bench for the register-file write-port
// controller, with a behavioural register file committing its writes.
module tb_reg_file_wb_ctrl;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid;
  logic            alu_ready, mem_ready;
  logic [4:0]      alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic            reg_write;
  logic            init_done;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] rf [NREG];

  reg_file_wb_ctrl #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  // Behavioural register file: starts with junk, commits on the clock edge.
  initial for (int i = 0; i < NREG; i++) rf[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
  always @(posedge clock) if (reg_write) rf[write_reg] <= write_data;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard,
                               input logic [XLEN-1:0] ad, input logic mv,
                               input logic [4:0] mrd, input logic [XLEN-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks the 32-edge zero sweep following reset deassertion.
  task automatic checkSweep(input string tag, input logic alu_pending);
    for (int k = 1; k <= 32; k++) begin
      tick();
      checkOutput({tag, "_we"},   64'(reg_write),  64'd1);
      checkOutput({tag, "_idx"},  64'(write_reg),  64'(k - 1));
      checkOutput({tag, "_data"}, write_data,      64'd0);
      checkOutput({tag, "_done"}, 64'(init_done),  64'(k == 32));
      if (alu_pending && k < 32)
        checkOutput({tag, "_rdy"}, 64'(alu_ready), 64'd0);
    end
  endtask

  int exp_idx [6] = '{1, 11, 2, 12, 3, 13};

  initial begin
    int ai, mi;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_we",   64'(reg_write), 64'd0);
    checkOutput("rst_idx",  64'(write_reg), 64'd0);
    checkOutput("rst_data", write_data,     64'd0);
    checkOutput("rst_done", 64'(init_done), 64'd0);
    reset = 1'b0;
    checkSweep("sweep", 1'b0);

    // One idle edge lets the final sweep write commit.
    tick();
    checkOutput("idle_we", 64'(reg_write), 64'd0);
    for (int i = 0; i < NREG; i++) checkOutput("rf_zero", rf[i], 64'd0);

    // Single ALU source.
    applyStimulus(1, 5, 64'hA5A5, 0, 0, 0);
    checkOutput("single_ardy", 64'(alu_ready), 64'd1);
    checkOutput("single_mrdy", 64'(mem_ready), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single_we",   64'(reg_write), 64'd1);
    checkOutput("single_idx",  64'(write_reg), 64'd5);
    checkOutput("single_data", write_data,     64'hA5A5);

    // Load to x0 is accepted but produces no write.
    applyStimulus(0, 0, 0, 1, 0, 64'hFFFF);
    checkOutput("x0_mrdy", 64'(mem_ready), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("x0_we",   64'(reg_write), 64'd0);
    checkOutput("x0_idx",  64'(write_reg), 64'd0);
    checkOutput("x0_data", write_data,     64'd0);
    checkOutput("rf5",     rf[5],          64'hA5A5);

    // Continuous contention: grants alternate starting with ALU.
    ai = 1;
    mi = 11;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 5'(ai), 64'h100 + 64'(ai), 1, 5'(mi), 64'h200 + 64'(mi));
      checkOutput("cont_ardy", 64'(alu_ready), 64'(i % 2 == 0));
      checkOutput("cont_mrdy", 64'(mem_ready), 64'(i % 2 == 1));
      tick();
      checkOutput("cont_idx", 64'(write_reg), 64'(exp_idx[i]));
      checkOutput("cont_we",  64'(reg_write), 64'd1);
      if (i % 2 == 0) ai++;
      else            mi++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("cont_last_data", write_data, 64'h20D);

    // Same destination from both sources: ALU first, MEM overwrites.
    applyStimulus(1, 7, 64'h1, 1, 7, 64'h2);
    checkOutput("same_ardy", 64'(alu_ready), 64'd1);
    tick();
    checkOutput("same1_data", write_data, 64'h1);
    checkOutput("same1_idx",  64'(write_reg), 64'd7);
    applyStimulus(0, 0, 0, 1, 7, 64'h2);
    checkOutput("same_mrdy", 64'(mem_ready), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("same2_data", write_data, 64'h2);
    tick();
    checkOutput("same_idle_we", 64'(reg_write), 64'd0);
    checkOutput("same_idle_hold", write_data, 64'h2);
    checkOutput("rf7",  rf[7],  64'h2);
    checkOutput("rf0",  rf[0],  64'd0);
    checkOutput("rf1",  rf[1],  64'h101);
    checkOutput("rf12", rf[12], 64'h20C);

    // Mid-sweep reset with an ALU request pending.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    checkOutput("mid_idx9", 64'(write_reg), 64'd9);
    applyStimulus(1, 3, 64'h33, 0, 0, 0);
    checkOutput("mid_ardy", 64'(alu_ready), 64'd0);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_we",   64'(reg_write), 64'd0);
    checkOutput("mid_rst_idx",  64'(write_reg), 64'd0);
    checkOutput("mid_rst_done", 64'(init_done), 64'd0);
    checkOutput("mid_rst_ardy", 64'(alu_ready), 64'd0);
    reset = 1'b0;
    checkSweep("resweep", 1'b1);
    checkOutput("resweep_ardy", 64'(alu_ready), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_idx",  64'(write_reg), 64'd3);
    checkOutput("post_data", write_data,     64'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_wb_ctrl.md
# reg_file_wb_ctrl

Write-port controller for the 32 x 64-bit register file (`reg_file`). After reset it sweeps all 32 registers to zero through the single write port. It then shares that port between two writeback sources, the ALU and the load unit, using valid/ready handshakes and round-robin arbitration. It drives `write_reg`, `write_data` and `reg_write` of `reg_file` directly from registers.

## Interface
Parameters:
- `XLEN`, 64, data width; must match `reg_file` data width.
- `NREG`, 32, register count; the register index is `$clog2(NREG)` = 5 bits.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU has a writeback pending.
- `alu_ready`  out  1  ALU writeback is accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  load unit has a writeback pending.
- `mem_ready`  out  1  load writeback is accepted this cycle.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load data.
- `write_reg`  out  5  to `reg_file` write index; registered.
- `write_data`  out  XLEN  to `reg_file` write data; registered.
- `reg_write`  out  1  to `reg_file` write enable; registered.
- `init_done`  out  1  high once the zero sweep is complete; registered.

## Operation
- States: INIT (zero sweep) and ARB (arbitration). A 5-bit sweep counter `cnt` and a 1-bit `last` (last granted source: 0 = ALU, 1 = MEM).
- Reset edge: state = INIT, `cnt` = 0, `last` = MEM, `reg_write` = 0, `write_reg` = 0, `write_data` = 0, `init_done` = 0.
- INIT, each edge:
  - Register the write `write_reg` = `cnt`, `write_data` = 0, `reg_write` = 1.
  - Increment `cnt`.
  - On the edge that issues `cnt` = 31: go to ARB and set `init_done` = 1.
  - x0 is included in the sweep.
- INIT readies: `alu_ready` = `mem_ready` = 0.
- ARB grant, combinational from state, `last`, `alu_valid` and `mem_valid`:
  - Only one source valid: that source is granted.
  - Both valid: the source other than `last` is granted.
  - Neither valid: no grant.
- ARB readies: `alu_ready` = ALU granted; `mem_ready` = MEM granted. At most one ready is high per cycle.
- Handshake: a transfer occurs when valid && ready. A source must hold valid, rd and data stable until accepted. Valid must not depend on ready.
- On a transfer:
  - Next edge registers `write_reg` = rd, `write_data` = data, `reg_write` = (rd != 0).
  - `last` updates to the granted source.
  - A write to x0 is accepted but dropped: `reg_write` = 0, `write_reg` = 0, `write_data` = 0.
- ARB with no transfer: next edge `reg_write` = 0; `write_reg` and `write_data` hold.
- `init_done` stays 1 until the next reset.
- Same rd from both sources in one cycle: the grant order decides. The later write lands one cycle after the earlier one, so it overwrites the first.
- Reset in any state, including mid-sweep or with an accepted write registered: the state returns to INIT and the sweep restarts at x0. The registered write is discarded (`reg_write` = 0 at the reset edge).

## Timing
- Sweep: the 32 edges after reset deasserts carry `reg_write` = 1 with `write_reg` = 0..31. `init_done` rises on the 32nd edge. Readies may be high from the cycle after that edge.
- Writeback latency: a handshake in cycle N presents the write on the outputs after edge N+1. `reg_file` commits it at edge N+2.
- Throughput: one writeback per cycle in total. Under continuous contention each source gets exactly one grant every 2 cycles.
- Readies are combinational from registered state and the input valids; there is no combinational path from data or rd inputs to any output.
- `reg_file` read data reflects a write only after its commit edge. This block performs no bypassing.

## Test plan
- Sweep: reset high 2 cycles, then low with both valids 0.
  - Expect 32 consecutive cycles of `reg_write` = 1, `write_reg` 0..31, `write_data` = 0.
  - Expect `init_done` = 1 after the 32nd; `reg_file` then reads 0 on all registers.
- Single source: after init, ALU valid with rd = 5, data = 0xA5A5.
  - Expect `alu_ready` = 1 in the same cycle.
  - Expect `reg_write` = 1, `write_reg` = 5 next cycle; register 5 reads 0xA5A5 afterward.
- Contention: both valid continuously for 6 cycles, ALU rd = 1..3, MEM rd = 11..13.
  - Expect grants ALU, MEM, ALU, MEM, ALU, MEM.
  - Expect `write_reg` sequence 1, 11, 2, 12, 3, 13.
- x0 drop: MEM writes rd = 0, data = 0xFFFF.
  - Expect `mem_ready` = 1 and `reg_write` = 0 on the following cycle.
  - Register 0 still reads 0.
- Same rd: both valid with rd = 7, ALU data 0x1 and MEM data 0x2, `last` = MEM.
  - Expect the ALU write first, then MEM.
  - Register 7 finally reads 0x2.
- Mid-sweep reset: assert reset at sweep cycle 10 with an ALU valid pending.
  - Expect `reg_write` = 0 at the reset edge and no ALU acceptance.
  - Expect the sweep to restart at `write_reg` = 0 and `init_done` to stay 0 until 32 edges later.
